// File: rtl/color_pkg.sv
// Shared pixel layout, drain FSM encoding and region limits for the colour
// region sampler.
package color_pkg;
  localparam int MAX_REGIONS = 8;
  localparam int R_HI = 11, R_LO = 8;
  localparam int G_HI = 7,  G_LO = 4;
  localparam int B_HI = 3,  B_LO = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic { ST_IDLE = 1'b0, ST_DRAIN = 1'b1 } drain_st_t;

  function automatic rgb444_t unpack_rgb(input logic [11:0] px);
    rgb444_t v;
    v.r = px[R_HI:R_LO];
    v.g = px[G_HI:G_LO];
    v.b = px[B_HI:B_LO];
    return v;
  endfunction
endpackage

// File: rtl/region_accum.sv
// One sample window: in-window test, per-channel accumulation and an
// end-of-frame snapshot that drives the averaged colour and clip flag.
module region_accum
  import color_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WIN_LOG2 = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_acc,
  input  logic    i_snap,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  input  logic [9:0] i_cx,
  input  logic [8:0] i_cy,
  input  rgb444_t i_pix,
  output rgb444_t o_avg,
  output logic    o_clip
);
  localparam int SIDE = 1 << WIN_LOG2;
  localparam int HALF = SIDE / 2;
  localparam int SW   = 4 + 2 * WIN_LOG2;

  int w_xlo, w_xhi, w_ylo, w_yhi, w_px, w_py;
  logic w_in, w_clip;
  logic [SW-1:0] w_add_r, w_add_g, w_add_b;
  logic [SW-1:0] r_sum_r, r_sum_g, r_sum_b;
  logic [SW-1:0] r_snap_r, r_snap_g, r_snap_b;
  logic r_clip;

  // Bounds are signed so windows hanging off the left/top edge compare correctly.
  always_comb begin
    w_px   = $signed({22'd0, i_x});
    w_py   = $signed({23'd0, i_y});
    w_xlo  = $signed({22'd0, i_cx}) - HALF;
    w_ylo  = $signed({23'd0, i_cy}) - HALF;
    w_xhi  = w_xlo + SIDE - 1;
    w_yhi  = w_ylo + SIDE - 1;
    w_in   = (w_px >= w_xlo) && (w_px <= w_xhi) && (w_py >= w_ylo) && (w_py <= w_yhi);
    w_clip = (w_xlo < 0) || (w_xhi > H_ACTIVE - 1) || (w_ylo < 0) || (w_yhi > V_ACTIVE - 1);
    w_add_r = w_in ? SW'(i_pix.r) : '0;
    w_add_g = w_in ? SW'(i_pix.g) : '0;
    w_add_b = w_in ? SW'(i_pix.b) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_r  <= '0; r_sum_g  <= '0; r_sum_b  <= '0;
      r_snap_r <= '0; r_snap_g <= '0; r_snap_b <= '0;
      r_clip   <= 1'b0;
    end else if (i_snap) begin
      r_snap_r <= r_sum_r + w_add_r;
      r_snap_g <= r_sum_g + w_add_g;
      r_snap_b <= r_sum_b + w_add_b;
      r_clip   <= w_clip;
      r_sum_r  <= '0; r_sum_g <= '0; r_sum_b <= '0;
    end else if (i_acc) begin
      r_sum_r <= r_sum_r + w_add_r;
      r_sum_g <= r_sum_g + w_add_g;
      r_sum_b <= r_sum_b + w_add_b;
    end
  end

  assign o_avg.r = 4'(r_snap_r >> (2 * WIN_LOG2));
  assign o_avg.g = 4'(r_snap_g >> (2 * WIN_LOG2));
  assign o_avg.b = 4'(r_snap_b >> (2 * WIN_LOG2));
  assign o_clip  = r_clip;
endmodule

// File: rtl/color_region_sampler.sv
// Raster tracker feeding N window accumulators; each frame's averages are
// drained over a valid/ready stream while the next frame accumulates.
module color_region_sampler
  import color_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int N_REGIONS = 4,
  parameter int WIN_LOG2  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [11:0]            video_data,
  input  logic                   vga_ready,
  input  logic [N_REGIONS*10-1:0] region_cx,
  input  logic [N_REGIONS*9-1:0]  region_cy,
  output logic [9:0]             x_count,
  output logic [8:0]             y_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_index,
  output logic [11:0]            out_rgb,
  output logic                   out_clipped,
  output logic                   overrun,
  input  logic                   overrun_clr
);
  logic [9:0] r_x;
  logic [8:0] r_y;
  logic w_xend, w_yend, w_first, w_last;
  logic [N_REGIONS*10-1:0] r_cx, w_cx;
  logic [N_REGIONS*9-1:0]  r_cy, w_cy;
  rgb444_t w_pix;
  rgb444_t [N_REGIONS-1:0] w_avg;
  logic [N_REGIONS-1:0] w_clip;

  assign w_xend  = (r_x == 10'(H_ACTIVE - 1));
  assign w_yend  = (r_y == 9'(V_ACTIVE - 1));
  assign w_first = vga_ready && (r_x == '0) && (r_y == '0);
  assign w_last  = vga_ready && w_xend && w_yend;
  // The (0,0) pixel must already see the centres being latched on that edge.
  assign w_cx  = w_first ? region_cx : r_cx;
  assign w_cy  = w_first ? region_cy : r_cy;
  assign w_pix = unpack_rgb(video_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0; r_y <= '0; r_cx <= '0; r_cy <= '0;
    end else if (vga_ready) begin
      if (w_xend) begin
        r_x <= '0;
        r_y <= w_yend ? '0 : r_y + 9'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
      if (w_first) begin
        r_cx <= region_cx;
        r_cy <= region_cy;
      end
    end
  end

  for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_reg
    region_accum #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .WIN_LOG2(WIN_LOG2)) u_acc (
      .clk, .rst_n,
      .i_acc (vga_ready),
      .i_snap(w_last),
      .i_x   (r_x),
      .i_y   (r_y),
      .i_cx  (w_cx[gi*10 +: 10]),
      .i_cy  (w_cy[gi*9 +: 9]),
      .i_pix (w_pix),
      .o_avg (w_avg[gi]),
      .o_clip(w_clip[gi])
    );
  end

  drain_st_t r_st, w_st_nxt;
  logic [2:0] r_idx;
  logic r_ovr, w_xfer, w_idx_last, w_ovr_evt;

  assign w_xfer     = out_valid && out_ready;
  assign w_idx_last = (r_idx == 3'(N_REGIONS - 1));
  assign w_ovr_evt  = w_last && (r_st == ST_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= ST_IDLE;
    else        r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_IDLE:  if (w_last) w_st_nxt = ST_DRAIN;
      ST_DRAIN: if (!w_last && w_xfer && w_idx_last) w_st_nxt = ST_IDLE;
      default:  w_st_nxt = ST_IDLE;
    endcase
  end

  // A fresh snapshot always restarts the drain, even mid-transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (w_last)      r_idx <= '0;
      else if (w_xfer) r_idx <= w_idx_last ? 3'd0 : r_idx + 3'd1;
      if (w_ovr_evt)        r_ovr <= 1'b1;
      else if (overrun_clr) r_ovr <= 1'b0;
    end
  end

  always_comb begin
    out_valid   = (r_st == ST_DRAIN);
    out_rgb     = '0;
    out_clipped = 1'b0;
    if (out_valid) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (r_idx == 3'(i)) begin
          out_rgb     = w_avg[i];
          out_clipped = w_clip[i];
        end
      end
    end
  end

  assign out_index = r_idx;
  assign overrun   = r_ovr;
  assign x_count   = r_x;
  assign y_count   = r_y;
endmodule

// File: tb/tb_color_region_sampler.sv
// Bench for color_region_sampler on a small 16x12 raster: directed frame
// table, overrun/reset sequences and randomized frames against a window model.
`timescale 1ns/1ps
module tb_color_region_sampler;
  localparam int H = 16, V = 12, N = 2, WL = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [11:0] video_data;
  logic vga_ready, out_ready, overrun_clr;
  logic [N*10-1:0] region_cx;
  logic [N*9-1:0]  region_cy;
  logic [9:0] x_count;
  logic [8:0] y_count;
  logic out_valid, out_clipped, overrun;
  logic [2:0] out_index;
  logic [11:0] out_rgb;

  always #5 clk = ~clk;

  color_region_sampler #(.H_ACTIVE(H), .V_ACTIVE(V), .N_REGIONS(N), .WIN_LOG2(WL)) dut (
    .clk(clk), .rst_n(rst_n), .video_data(video_data), .vga_ready(vga_ready),
    .region_cx(region_cx), .region_cy(region_cy), .x_count(x_count), .y_count(y_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_rgb(out_rgb),
    .out_clipped(out_clipped), .overrun(overrun), .overrun_clr(overrun_clr));

  typedef struct { logic [2:0] idx; logic [11:0] rgb; logic clip; } res_t;
  typedef struct { int pat; logic [11:0] base; logic [19:0] cx; logic [17:0] cy;
                   logic [11:0] e0; logic c0; logic [11:0] e1; logic c1; } vec_t;

  res_t obs_q[$], exp_q[$];
  int img[V][H];
  int checks = 0, failures = 0, raster_err = 0, stall_err = 0;
  bit stall_en = 0, p_stall = 0;
  logic [15:0] p_res = '0;
  vec_t tbl[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Collects every transfer and watches that stalled results hold still.
  always @(negedge clk) begin
    if (stall_en && p_stall && out_valid && ({out_index, out_rgb, out_clipped} !== p_res))
      stall_err++;
    if (out_valid && out_ready) obs_q.push_back('{out_index, out_rgb, out_clipped});
    p_stall = out_valid && !out_ready;
    p_res   = {out_index, out_rgb, out_clipped};
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_frame(input int pat, input logic [11:0] base, input logic [N*10-1:0] cx,
                             input logic [N*9-1:0] cy, input int npix, input bit rnd, input bit clr_last);
    int n, pv;
    n = 0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (n == npix) begin vga_ready = 1'b0; return; end
        if (rnd) begin
          for (int g = 0; g < 3 && $urandom_range(3) == 0; g++) begin
            vga_ready = 1'b0; video_data = 12'($urandom);
            region_cx = N*10'($urandom); region_cy = N*9'($urandom);
            out_ready = ($urandom_range(9) < 7);
            tick();
          end
        end
        if (x_count !== 10'(x) || y_count !== 9'(y)) raster_err++;
        case (pat)
          0:       pv = base;
          1:       pv = (x < cx[9:0]) ? 0 : 12'hFFF;
          default: pv = $urandom_range(12'hFFF);
        endcase
        img[y][x] = pv;
        video_data = pv[11:0];
        vga_ready = 1'b1;
        if (n == 0) begin region_cx = cx; region_cy = cy; end
        else if (rnd) begin region_cx = N*10'($urandom); region_cy = N*9'($urandom); end
        if (rnd) out_ready = ($urandom_range(9) < 7);
        overrun_clr = clr_last && (n == H*V - 1);
        tick();
        n++;
      end
    end
    vga_ready = 1'b0;
    overrun_clr = 1'b0;
  endtask

  // Reference: walk each window over the captured frame image.
  task automatic model_frame(input logic [N*10-1:0] cx, input logic [N*9-1:0] cy);
    for (int r = 0; r < N; r++) begin
      int lox, loy, sr, sg, sb, px, py;
      bit clip;
      lox = int'(cx[r*10 +: 10]) - (1 << WL) / 2;
      loy = int'(cy[r*9 +: 9]) - (1 << WL) / 2;
      sr = 0; sg = 0; sb = 0; clip = 0;
      for (int dy = 0; dy < (1 << WL); dy++)
        for (int dx = 0; dx < (1 << WL); dx++) begin
          px = lox + dx; py = loy + dy;
          if (px < 0 || px >= H || py < 0 || py >= V) clip = 1;
          else begin
            sr += (img[py][px] >> 8) & 15;
            sg += (img[py][px] >> 4) & 15;
            sb += img[py][px] & 15;
          end
        end
      exp_q.push_back('{3'(r), {4'(sr >> (2*WL)), 4'(sg >> (2*WL)), 4'(sb >> (2*WL))}, clip});
    end
  endtask

  task automatic cmp_q(input string nm);
    check({nm, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check(nm, {obs_q[i].idx, obs_q[i].rgb, obs_q[i].clip}, {exp_q[i].idx, exp_q[i].rgb, exp_q[i].clip});
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    logic [N*10-1:0] rcx;
    logic [N*9-1:0]  rcy;
    tbl[0] = '{0, 12'hA5C, {10'd3, 10'd8},  {9'd2, 9'd6},  12'hA5C, 1'b0, 12'hA5C, 1'b0};
    tbl[1] = '{1, 12'h000, {10'd12, 10'd5}, {9'd3, 9'd6},  12'h777, 1'b0, 12'hFFF, 1'b0};
    tbl[2] = '{0, 12'hFFF, {10'd15, 10'd0}, {9'd11, 9'd0}, 12'h333, 1'b1, 12'h888, 1'b1};
    tbl[3] = '{0, 12'h123, {10'd14, 10'd2}, {9'd10, 9'd2}, 12'h123, 1'b0, 12'h123, 1'b0};
    tbl[4] = '{0, 12'h3C9, {10'd7, 10'd7},  {9'd5, 9'd5},  12'h3C9, 1'b0, 12'h3C9, 1'b0};
    tbl[5] = '{0, 12'h8F1, {10'd8, 10'd1},  {9'd12, 9'd5}, 12'h6B0, 1'b1, 12'h470, 1'b1};

    video_data = '0; vga_ready = 0; region_cx = '0; region_cy = '0;
    out_ready = 1; overrun_clr = 0; rst_n = 0;
    #12;
    check("rst_x", x_count, 0);
    check("rst_y", y_count, 0);
    check("rst_outs", {out_valid, out_index, out_rgb, out_clipped, overrun}, 0);
    tick(); rst_n = 1; tick();

    stall_en = 1;
    for (int t = 0; t < 6; t++) begin
      obs_q.delete();
      drive_frame(tbl[t].pat, tbl[t].base, tbl[t].cx, tbl[t].cy, H*V, 0, 0);
      @(negedge clk);
      check("latency_valid", {out_valid, out_index}, {1'b1, 3'd0});
      repeat (4) tick();
      exp_q.push_back('{3'd0, tbl[t].e0, tbl[t].c0});
      exp_q.push_back('{3'd1, tbl[t].e1, tbl[t].c1});
      cmp_q("table");
      check("table_overrun", overrun, 0);
    end
    stall_en = 0;

    // Overrun: stall across two frame ends, with one transfer in between.
    out_ready = 0;
    drive_frame(0, 12'h111, tbl[0].cx, tbl[0].cy, H*V, 0, 0);
    check("ovr_stall_rgb", {out_valid, out_rgb}, {1'b1, 12'h111});
    out_ready = 1; tick(); out_ready = 0;
    check("ovr_mid_index", out_index, 1);
    check("ovr_before", overrun, 0);
    drive_frame(0, 12'h222, tbl[0].cx, tbl[0].cy, H*V, 0, 0);
    check("ovr_set", overrun, 1);
    check("ovr_restart", {out_valid, out_index, out_rgb}, {1'b1, 3'd0, 12'h222});
    overrun_clr = 1; tick(); overrun_clr = 0;
    check("ovr_clr", overrun, 0);
    out_ready = 1; repeat (4) tick();
    exp_q.push_back('{3'd0, 12'h111, 1'b0});
    exp_q.push_back('{3'd0, 12'h222, 1'b0});
    exp_q.push_back('{3'd1, 12'h222, 1'b0});
    cmp_q("ovr_drain");

    // Clear coincident with a new overrun keeps the flag.
    out_ready = 0;
    drive_frame(0, 12'h333, tbl[0].cx, tbl[0].cy, H*V, 0, 0);
    drive_frame(0, 12'h444, tbl[0].cx, tbl[0].cy, H*V, 0, 1);
    check("ovr_clr_coincident", overrun, 1);

    // Reset mid-frame while draining discards everything.
    drive_frame(2, 12'h000, tbl[0].cx, tbl[0].cy, 50, 0, 0);
    rst_n = 0; #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_raster", {x_count, y_count}, 0);
    check("rst_mid_state", {out_index, out_rgb, out_clipped, overrun}, 0);
    tick(); rst_n = 1;
    out_ready = 1; obs_q.delete();
    repeat (8) tick();
    check("no_stale", obs_q.size(), 0);
    drive_frame(2, 12'h000, {10'd4, 10'd5}, {9'd0, 9'd9}, H*V, 0, 0);
    model_frame({10'd4, 10'd5}, {9'd0, 9'd9});
    repeat (4) tick();
    cmp_q("post_reset");

    // Random frames back to back: drain overlaps the next frame.
    stall_en = 1;
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < N; r++) begin
        rcx[r*10 +: 10] = 10'($urandom_range(H-1));
        rcy[r*9 +: 9]   = 9'($urandom_range(V-1));
      end
      drive_frame(2, 12'h000, rcx, rcy, H*V, 1, 0);
      model_frame(rcx, rcy);
    end
    out_ready = 1;
    repeat (10) tick();
    stall_en = 0;
    cmp_q("random");
    check("random_overrun", overrun, 0);
    check("raster", raster_err, 0);
    check("stall_stable", stall_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
